// File: rtl/v810_mem_arbiter_pkg.sv
// Shared types and default sizes for the V810 memory arbiter slice.
// Imported by the interface, the priority selector and the arbiter top.
package v810_mem_pkg;

  localparam int DEF_AW           = 20;
  localparam int DEF_DW           = 32;
  localparam int DEF_CPU_MAX_WAIT = 8;

  typedef enum logic [1:0] {
    OWN_LD,
    OWN_VID,
    OWN_CPU
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_ACK
  } arb_state_t;

endpackage

// File: rtl/v810_mem_arbiter_if.sv
// Requester and memory-controller signals around the V810 memory arbiter.
// slave = arbiter side, master = requesters plus memory controller.
interface v810_mem_arbiter_if
  import v810_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
  logic          ld_busy;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [3:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  ld_req, ld_addr, ld_wdata,
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  mem_ack, mem_rdata,
    output ld_ack, ld_busy, vid_ack, vid_rdata, cpu_ack, cpu_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output ld_req, ld_addr, ld_wdata,
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output mem_ack, mem_rdata,
    input  ld_ack, ld_busy, vid_ack, vid_rdata, cpu_ack, cpu_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/v810_mem_arbiter_prio.sv
// Fixed-priority winner select (ld > vid > cpu) with a CPU starvation guard:
// after CPU_MAX_WAIT consecutive video wins over a waiting CPU, the CPU beats video.
module v810_arb_prio
  import v810_mem_pkg::*;
#(
  parameter int CPU_MAX_WAIT = DEF_CPU_MAX_WAIT
) (
  input  logic   clk_sys,
  input  logic   reset,
  input  logic   ld_req,
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   grant_en,
  output owner_t winner,
  output logic   grant_vld
);

  localparam int CW = $clog2(CPU_MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          cpu_forced;

  always_comb begin
    cpu_forced = (wait_cnt == CW'(CPU_MAX_WAIT));
    grant_vld  = ld_req | vid_req | cpu_req;
    winner     = OWN_CPU;
    if (ld_req) begin
      winner = OWN_LD;
    end else if (vid_req && !(cpu_req && cpu_forced)) begin
      winner = OWN_VID;
    end
  end

  // Counts video wins while the CPU is waiting; a CPU that lets go forgets its debt.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!cpu_req) begin
      wait_cnt <= '0;
    end else if (grant_en && grant_vld) begin
      if (winner == OWN_CPU) begin
        wait_cnt <= '0;
      end else if (winner == OWN_VID && !cpu_forced) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/v810_mem_arbiter.sv
// Serialises loader, video and CPU accesses onto one single-port memory.
// One access at a time: IDLE (arbitrate) -> MEM (wait mem_ack) -> ACK (pulse requester).
module v810_mem_arbiter
  import v810_mem_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int CPU_MAX_WAIT = DEF_CPU_MAX_WAIT
) (
  input logic               clk_sys,
  input logic               reset,
  v810_mem_arbiter_if.slave bus
);

  arb_state_t    state;
  arb_state_t    state_nxt;
  owner_t        owner;
  owner_t        winner;
  logic          grant_vld;
  logic          load;
  logic          capture;

  logic          mem_we_q;
  logic [3:0]    mem_be_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] vid_rdata_q;
  logic [DW-1:0] cpu_rdata_q;

  v810_arb_prio #(
    .CPU_MAX_WAIT (CPU_MAX_WAIT)
  ) u_prio (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ld_req    (bus.ld_req),
    .vid_req   (bus.vid_req),
    .cpu_req   (bus.cpu_req),
    .grant_en  (state == ST_IDLE),
    .winner    (winner),
    .grant_vld (grant_vld)
  );

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets its default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          load      = 1'b1;
          state_nxt = ST_MEM;
        end
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          capture   = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the rdata holding registers are cleared on reset like every other output.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      owner       <= OWN_LD;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      if (load) begin
        owner <= winner;
        case (winner)
          OWN_LD: begin
            mem_we_q    <= 1'b1;
            mem_be_q    <= 4'hF;
            mem_addr_q  <= bus.ld_addr;
            mem_wdata_q <= bus.ld_wdata;
          end
          OWN_VID: begin
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'hF;
            mem_addr_q  <= bus.vid_addr;
            mem_wdata_q <= '0;
          end
          default: begin
            mem_we_q    <= bus.cpu_we;
            mem_be_q    <= bus.cpu_be;
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
          end
        endcase
      end
      if (capture) begin
        if (owner == OWN_VID) vid_rdata_q <= bus.mem_rdata;
        if (owner == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = (state == ST_MEM);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.ld_ack    = (state == ST_ACK) && (owner == OWN_LD);
  assign bus.vid_ack   = (state == ST_ACK) && (owner == OWN_VID);
  assign bus.cpu_ack   = (state == ST_ACK) && (owner == OWN_CPU);
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ld_busy   = (state != ST_IDLE) && (owner == OWN_LD);

endmodule

// File: tb/tb_v810_mem_arbiter.sv
// Self-checking bench for v810_mem_arbiter: behavioural memory device plus a
// transaction-level grant-order and data model derived from the arbitration rules.
module tb_v810_mem_arbiter;

  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int MAXW = 8;
  localparam int LD   = 0;
  localparam int VID  = 1;
  localparam int CPU  = 2;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  v810_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  v810_mem_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .CPU_MAX_WAIT (MAXW)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  // Memory device: answers mem_req after mem_lat extra cycles, returns old contents.
  logic [31:0] dev_mem [int];
  int          mem_lat   = 0;
  bit          mem_hold  = 1'b0;
  int          spur_req  = 0;
  int          spur_done = 0;
  int          lat_cnt   = 0;
  int          dev_a;
  logic [31:0] dev_old;

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk_sys) begin
    bus.mem_ack = 1'b0;
    if (spur_req != spur_done) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
      spur_done     = spur_req;
    end else if (bus.mem_req === 1'b1 && !mem_hold) begin
      if (lat_cnt >= mem_lat) begin
        dev_a   = int'(bus.mem_addr);
        dev_old = dev_mem.exists(dev_a) ? dev_mem[dev_a] : 32'h0;
        bus.mem_rdata = dev_old;
        if (bus.mem_we) dev_mem[dev_a] = merge_be(dev_old, bus.mem_wdata, bus.mem_be);
        bus.mem_ack = 1'b1;
        lat_cnt     = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // Requester stimulus and reference state.
  logic          req_v     [3];
  logic          cur_we    [3];
  logic [3:0]    cur_be    [3];
  logic [AW-1:0] cur_addr  [3];
  logic [DW-1:0] cur_wdata [3];
  logic [31:0]   ref_mem   [int];
  logic [31:0]   exp_vid_rdata = '0;
  logic [31:0]   exp_cpu_rdata = '0;
  int            ld_addr_fix   = -1;
  bit            fix_cpu_pending = 1'b0;
  logic          fix_we = 1'b0;
  logic [3:0]    fix_be = 4'h0;

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [125:0] outs();
    return {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
            bus.ld_ack, bus.vid_ack, bus.cpu_ack, bus.vid_rdata, bus.cpu_rdata, bus.ld_busy};
  endfunction

  task automatic drive_bus();
    bus.ld_req    = req_v[LD];
    bus.ld_addr   = cur_addr[LD];
    bus.ld_wdata  = cur_wdata[LD];
    bus.vid_req   = req_v[VID];
    bus.vid_addr  = cur_addr[VID];
    bus.cpu_req   = req_v[CPU];
    bus.cpu_we    = cur_we[CPU];
    bus.cpu_be    = cur_be[CPU];
    bus.cpu_addr  = cur_addr[CPU];
    bus.cpu_wdata = cur_wdata[CPU];
  endtask

  task automatic new_fields(input int k);
    cur_addr[k]  = AW'($urandom_range(0, 15));
    cur_wdata[k] = $urandom;
    cur_we[k]    = (k == LD);
    cur_be[k]    = 4'hF;
    if (k == LD && ld_addr_fix >= 0) cur_addr[k] = AW'(ld_addr_fix);
    if (k == CPU) begin
      if (fix_cpu_pending) begin
        cur_we[k] = fix_we;
        cur_be[k] = fix_be;
        fix_cpu_pending = 1'b0;
      end else begin
        cur_we[k] = 1'($urandom_range(0, 1));
        cur_be[k] = 4'($urandom);
      end
    end
  endtask

  // Each requester makes n_* accesses back to back (renewing its req in the ack
  // cycle); the expected grant order follows from the priority and starvation rules.
  task automatic run_batch(input int n_ld, input int n_vid, input int n_cpu, input int lat);
    int          rem [3];
    int          r [3];
    int          order [$];
    int          w, win, idx, k, budget, prev_evt, issue_cyc, a;
    bit          first;
    logic        prev_req, exp_we;
    logic [3:0]  exp_be;
    logic [2:0]  ack_vec, exp_vec;
    logic [31:0] old, got;
    rem[LD] = n_ld; rem[VID] = n_vid; rem[CPU] = n_cpu;
    r = rem;
    w = 0;
    while (r[LD] + r[VID] + r[CPU] > 0) begin
      if (r[LD] > 0) win = LD;
      else if (r[VID] > 0 && !(r[CPU] > 0 && w == MAXW)) win = VID;
      else win = CPU;
      if (win == CPU) w = 0;
      else if (win == VID && r[CPU] > 0 && w < MAXW) w++;
      r[win]--;
      if (r[CPU] == 0) w = 0;
      order.push_back(win);
    end
    mem_lat = lat;
    for (int i = 0; i < 3; i++) begin
      req_v[i] = (rem[i] > 0);
      if (rem[i] > 0) new_fields(i);
    end
    drive_bus();
    prev_evt = cyc; issue_cyc = cyc; first = 1'b1; idx = 0; budget = 0; prev_req = 1'b0;
    while (idx < order.size() && budget < order.size() * (lat + 3) * 4 + 10) begin
      @(negedge clk_sys);
      budget++;
      k = order[idx];
      ack_vec = {bus.ld_ack, bus.vid_ack, bus.cpu_ack};
      if (bus.mem_req === 1'b1 && prev_req !== 1'b1) begin
        exp_we = (k == CPU) ? cur_we[CPU] : (k == LD);
        exp_be = (k == CPU) ? cur_be[CPU] : 4'hF;
        checks++;
        if ({bus.mem_we, bus.mem_be, bus.mem_addr} !== {exp_we, exp_be, cur_addr[k]} ||
            (exp_we && bus.mem_wdata !== cur_wdata[k])) begin
          failures++;
          $display("FAIL issue_fields req=%0d: got we=%b be=%h addr=%h wdata=%h, want we=%b be=%h addr=%h wdata=%h",
                   k, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, exp_we, exp_be, cur_addr[k], cur_wdata[k]);
        end
        checks++;
        if (cyc - prev_evt != (first ? 1 : 2)) begin
          failures++;
          $display("FAIL issue_gap req=%0d: got %0d cycles, want %0d", k, cyc - prev_evt, first ? 1 : 2);
        end
        checks++;
        if (bus.ld_busy !== (k == LD)) begin
          failures++;
          $display("FAIL ld_busy_issue req=%0d: got %b, want %b", k, bus.ld_busy, (k == LD));
        end
        issue_cyc = cyc;
      end
      prev_req = bus.mem_req;
      if (ack_vec !== 3'b000) begin
        exp_vec = 3'b100 >> k;
        checks++;
        if (ack_vec !== exp_vec) begin
          failures++;
          $display("FAIL grant_order idx=%0d: got acks(ld,vid,cpu)=%b, want %b", idx, ack_vec, exp_vec);
        end
        checks++;
        if (cyc - issue_cyc != lat + 1) begin
          failures++;
          $display("FAIL ack_latency req=%0d: got %0d, want %0d", k, cyc - issue_cyc, lat + 1);
        end
        checks++;
        if (bus.ld_busy !== (k == LD)) begin
          failures++;
          $display("FAIL ld_busy_ack req=%0d: got %b, want %b", k, bus.ld_busy, (k == LD));
        end
        a   = int'(cur_addr[k]);
        old = ref_rd(a);
        if (k != LD) begin
          got = (k == VID) ? bus.vid_rdata : bus.cpu_rdata;
          checks++;
          if (got !== old) begin
            failures++;
            $display("FAIL rdata req=%0d addr=%0h: got %h, want %h", k, a, got, old);
          end
          if (k == VID) exp_vid_rdata = old;
          else exp_cpu_rdata = old;
        end
        if (k == LD) ref_mem[a] = cur_wdata[k];
        else if (k == CPU && cur_we[CPU]) ref_mem[a] = merge_be(old, cur_wdata[k], cur_be[k]);
        rem[k]--;
        if (rem[k] > 0) new_fields(k);
        else req_v[k] = 1'b0;
        drive_bus();
        prev_evt = cyc;
        first = 1'b0;
        idx++;
      end
    end
    if (idx < order.size()) begin
      checks++;
      failures++;
      $display("FAIL batch_timeout: got %0d acks, want %0d", idx, order.size());
    end
    for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
    drive_bus();
    @(negedge clk_sys);
    checks++;
    if ({bus.mem_req, bus.ld_busy} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_batch: got mem_req,ld_busy=%b, want 00", {bus.mem_req, bus.ld_busy});
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 1'b0; cur_we[i] = 1'b0; cur_be[i] = '0; cur_addr[i] = '0; cur_wdata[i] = '0;
    end
    drive_bus();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, want 0", outs());
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL idle_no_req: got %h, want 0", outs());
    end
  endtask

  task automatic test_single_read();
    int          c0;
    logic [31:0] exp;
    ld_addr_fix = 16;
    run_batch(1, 0, 0, 0);
    ld_addr_fix = -1;
    exp = ref_rd(16);
    req_v[CPU] = 1'b1; cur_we[CPU] = 1'b0; cur_be[CPU] = 4'hF;
    cur_addr[CPU] = 20'h00010; cur_wdata[CPU] = '0;
    mem_lat = 0;
    drive_bus();
    c0 = cyc;
    @(negedge clk_sys);
    checks++;
    if ({bus.mem_req, bus.cpu_ack, bus.mem_addr} !== {2'b10, 20'h00010}) begin
      failures++;
      $display("FAIL single_cycle1: got mem_req=%b cpu_ack=%b addr=%h, want 1 0 00010",
               bus.mem_req, bus.cpu_ack, bus.mem_addr);
    end
    @(negedge clk_sys);
    checks++;
    if (bus.cpu_ack !== 1'b1 || cyc - c0 != 2) begin
      failures++;
      $display("FAIL single_ack: got cpu_ack=%b at cycle %0d, want 1 at cycle 2", bus.cpu_ack, cyc - c0);
    end
    checks++;
    if (bus.cpu_rdata !== exp) begin
      failures++;
      $display("FAIL single_rdata: got %h, want %h", bus.cpu_rdata, exp);
    end
    exp_cpu_rdata = exp;
    req_v[CPU] = 1'b0;
    drive_bus();
    @(negedge clk_sys);
    checks++;
    if ({bus.cpu_ack, bus.mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL single_pulse: got cpu_ack,mem_req=%b, want 00", {bus.cpu_ack, bus.mem_req});
    end
  endtask

  task automatic test_simultaneous();
    run_batch(1, 1, 1, 0);
  endtask

  task automatic test_starvation();
    run_batch(0, 12, 1, 0);
    run_batch(1, 10, 2, 1);
  endtask

  task automatic test_transfer_rules();
    fix_cpu_pending = 1'b1;
    fix_we = 1'b1;
    fix_be = 4'b0011;
    run_batch(0, 1, 1, 0);
  endtask

  task automatic test_reset_mid();
    bit got;
    req_v[CPU] = 1'b1; cur_we[CPU] = 1'b0; cur_be[CPU] = 4'hF;
    cur_addr[CPU] = 20'h00003; cur_wdata[CPU] = '0;
    mem_hold = 1'b1;
    drive_bus();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk_sys);
      if (bus.mem_req === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL reset_mid_issue: got no mem_req, want mem_req within 10 cycles");
    end
    reset = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h, want 0", outs());
    end
    exp_vid_rdata = '0;
    exp_cpu_rdata = '0;
    req_v[CPU] = 1'b0;
    drive_bus();
    reset = 1'b0;
    mem_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      checks++;
      if ({bus.ld_ack, bus.vid_ack, bus.cpu_ack, bus.mem_req} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_mid_quiet: got acks,mem_req=%b, want 0000",
                 {bus.ld_ack, bus.vid_ack, bus.cpu_ack, bus.mem_req});
      end
    end
    run_batch(0, 0, 1, 1);
  endtask

  task automatic test_spurious();
    spur_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      checks++;
      if ({bus.ld_ack, bus.vid_ack, bus.cpu_ack, bus.mem_req} !== 4'b0000 ||
          bus.vid_rdata !== exp_vid_rdata || bus.cpu_rdata !== exp_cpu_rdata) begin
        failures++;
        $display("FAIL spurious_ack: got acks,mem_req=%b vid_rdata=%h cpu_rdata=%h, want 0000 %h %h",
                 {bus.ld_ack, bus.vid_ack, bus.cpu_ack, bus.mem_req}, bus.vid_rdata, bus.cpu_rdata,
                 exp_vid_rdata, exp_cpu_rdata);
      end
    end
    run_batch(0, 1, 0, 0);
  endtask

  task automatic test_random();
    int n_ld, n_vid, n_cpu;
    for (int it = 0; it < 30; it++) begin
      n_ld  = $urandom_range(0, 2);
      n_vid = $urandom_range(0, 3);
      n_cpu = $urandom_range(0, 3);
      if (n_ld + n_vid + n_cpu == 0) n_cpu = 1;
      run_batch(n_ld, n_vid, n_cpu, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_starvation();
    test_transfer_rules();
    test_reset_mid();
    test_random();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
